ball_track_ctrl: RTL
====================

BALL_TRACK_CTRL -- requirements
Module: ball_track_ctrl

Interface
REQ-001 SHALL have parameter H_START, default 144: VGA_H_CNT value of first active pixel column.
REQ-002 SHALL have parameter V_START, default 35: VGA_V_CNT value of first active line.
REQ-003 SHALL have parameters H_ACT = 640 and V_ACT = 480: active-area width and height in pixels.
REQ-004 SHALL have parameter MIN_HITS, default 16: minimum hit pixels per frame for a valid detection.
REQ-005 SHALL have port CLK, input, 1: single clock (VGA pixel clock); all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port ENABLE, input, 1: tracking enable, level-sensitive.
REQ-008 SHALL have ports VGA_H_CNT and VGA_V_CNT, inputs, 13 each: raster counters.
REQ-009 SHALL have port VGA_VS, input, 1: vertical sync, active-low.
REQ-010 SHALL have port HIT, input, 1: current pixel classified as ball, aligned with the counters.
REQ-011 SHALL have port ACK, input, 1: host consumed the result.
REQ-012 SHALL have ports X_MIN, X_MAX, Y_MIN and Y_MAX, outputs, 10 each: published bounding box.
REQ-013 SHALL have port HIT_CNT, output, 19: published hit count.
REQ-014 SHALL have port FOUND, output, 1: published HIT_CNT >= MIN_HITS.
REQ-015 SHALL have port VALID, output, 1: result pending for host.
REQ-016 SHALL have port BUSY, output, 1: high in ACCUM.
REQ-017 SHALL have port DROP_CNT, output, 8: count of results overwritten before ACK.

Function
REQ-018 SHALL define the frame edge as a VGA_VS falling edge, detected via one register stage (VS_q=1, VS=0).
REQ-019 SHALL implement states IDLE, ARM, ACCUM, PUBLISH.
REQ-020 SHALL transition IDLE -> ARM when ENABLE=1; ARM -> ACCUM on frame edge, clearing accumulators that cycle; ACCUM -> PUBLISH on frame edge; PUBLISH -> ACCUM unconditionally after exactly 1 cycle, clearing accumulators.
REQ-021 SHALL go to IDLE from any state when ENABLE=0, discarding partial accumulators; published outputs and VALID SHALL be retained.
REQ-022 SHALL treat a pixel as active only when H_START <= VGA_H_CNT < H_START+H_ACT and V_START <= VGA_V_CNT < V_START+V_ACT; x = VGA_H_CNT-H_START and y = VGA_V_CNT-V_START, truncated to 10 bits.
REQ-023 SHALL, in ACCUM only, on an active pixel with HIT=1: increment hit counter (19 bit, saturating at 524287) and update min/max x/y.
REQ-024 SHALL initialise accumulators to min=1023, max=0, count=0.
REQ-025 SHALL ignore HIT outside active area or outside ACCUM.
REQ-026 SHALL, in PUBLISH, register HIT_CNT and FOUND; if FOUND=1, register the box; if FOUND=0, register box outputs as 0. VALID SHALL be 1 from the next cycle.
REQ-027 SHALL clear VALID on the cycle after ACK=1 while VALID=1; ACK while VALID=0 is ignored.
REQ-028 SHALL, if PUBLISH occurs while VALID=1 and ACK=0, increment DROP_CNT (saturating at 255).
REQ-029 SHALL, if ACK=1 in the PUBLISH cycle, keep VALID=1 with the new data and not increment DROP_CNT.
REQ-030 SHALL make a frame edge seen in the same cycle as the ENABLE rise count only from ARM, i.e. the first full frame is skipped.
REQ-031 SHALL give first-result latency = one full frame after arming plus 2 cycles from the frame edge to VALID=1.

Reset
REQ-032 SHALL, on RST=1, immediately force state IDLE, all outputs 0, DROP_CNT=0, accumulators to REQ-024 values and VS_q=1.
REQ-033 SHALL, after RST release, leave IDLE no earlier than the first CLK edge with ENABLE=1.

Verification
REQ-034 SHALL verify: ENABLE=1, 20-pixel blob at x 100..103 and y 200..204 in frame 2 -> VALID=1 two cycles after the frame 3 edge, box (100,103,200,204), HIT_CNT=20, FOUND=1.
REQ-035 SHALL verify: 5 hits in a frame -> HIT_CNT=5, FOUND=0, all box outputs 0.
REQ-036 SHALL verify: no ACK for 3 published frames -> DROP_CNT=2, outputs hold the latest frame; ACK asserted in a PUBLISH cycle -> VALID stays 1 and DROP_CNT is unchanged.
REQ-037 SHALL verify: HIT=1 at VGA_H_CNT=143 and at VGA_H_CNT=784 -> not counted; HIT=1 at 144 and 783 -> x=0 and x=639.
REQ-038 SHALL verify: ENABLE dropped mid-ACCUM -> IDLE next cycle, BUSY=0, prior VALID result retained; re-enable -> ARM, next result only after a full frame.
REQ-039 SHALL verify: RST pulse mid-ACCUM, asynchronous to CLK -> all outputs 0 before the next CLK edge.

Source files
------------

// File: rtl/ball_track_ctrl.sv
// Per-frame ball tracker: accumulates hit count and bounding box over one VGA frame,
// then publishes the result to a host that consumes it with ACK.
module ball_track_ctrl #(
  parameter int H_START  = 144,
  parameter int V_START  = 35,
  parameter int H_ACT    = 640,
  parameter int V_ACT    = 480,
  parameter int MIN_HITS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [12:0] VGA_H_CNT,
  input  logic [12:0] VGA_V_CNT,
  input  logic        VGA_VS,
  input  logic        HIT,
  input  logic        ACK,
  output logic [9:0]  X_MIN,
  output logic [9:0]  X_MAX,
  output logic [9:0]  Y_MIN,
  output logic [9:0]  Y_MAX,
  output logic [18:0] HIT_CNT,
  output logic        FOUND,
  output logic        VALID,
  output logic        BUSY,
  output logic [7:0]  DROP_CNT,
  output logic [1:0]  STATE_DBG
);

  // Host handshake: VALID rises the cycle after PUBLISH and stays high until the
  // host samples ACK=1 while VALID=1; a PUBLISH with VALID=1 and ACK=0 overwrites
  // the pending result and counts a drop, a PUBLISH with ACK=1 does not.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_ACCUM   = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  localparam logic [12:0] H_LO       = 13'(H_START);
  localparam logic [12:0] H_HI       = 13'(H_START + H_ACT);
  localparam logic [12:0] V_LO       = 13'(V_START);
  localparam logic [12:0] V_HI       = 13'(V_START + V_ACT);
  localparam logic [18:0] CNT_MAX    = '1;
  localparam logic [18:0] MIN_HITS_C = 19'(MIN_HITS);
  localparam logic [9:0]  MIN_INIT   = 10'd1023;
  localparam logic [7:0]  DROP_MAX   = 8'hFF;

  state_t      state;
  state_t      state_nxt;
  logic        vs_q;
  logic        frame_edge;
  logic        active;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        acc_hit;
  logic        acc_clr;
  logic        do_publish;
  logic        found_now;
  logic [18:0] acc_cnt;
  logic [9:0]  acc_xmin;
  logic [9:0]  acc_xmax;
  logic [9:0]  acc_ymin;
  logic [9:0]  acc_ymax;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= VGA_VS;
    end
  end

  assign frame_edge = vs_q & ~VGA_VS;

  assign active = (VGA_H_CNT >= H_LO) && (VGA_H_CNT < H_HI) &&
                  (VGA_V_CNT >= V_LO) && (VGA_V_CNT < V_HI);
  assign px_x   = 10'(VGA_H_CNT - H_LO);
  assign px_y   = 10'(VGA_V_CNT - V_LO);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a frame edge coinciding with the ENABLE rise only arms.
  always_comb begin
    state_nxt = state;
    if (!ENABLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_ARM;
        S_ARM:     if (frame_edge) state_nxt = S_ACCUM;
        S_ACCUM:   if (frame_edge) state_nxt = S_PUBLISH;
        S_PUBLISH: state_nxt = S_ACCUM;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    BUSY       = 1'b0;
    STATE_DBG  = state;
    acc_hit    = 1'b0;
    acc_clr    = 1'b1;
    do_publish = 1'b0;
    if (ENABLE) begin
      case (state)
        S_ACCUM: begin
          BUSY    = 1'b1;
          acc_clr = 1'b0;
          acc_hit = active & HIT;
        end
        S_PUBLISH: do_publish = 1'b1;
        default:   ;
      endcase
    end else if (state == S_ACCUM) begin
      BUSY = 1'b1;
    end
  end

  // Accumulators rest at their initial values outside ACCUM, so both the
  // ARM->ACCUM and PUBLISH->ACCUM entries start a frame from a clean slate.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_cnt  <= '0;
      acc_xmin <= MIN_INIT;
      acc_xmax <= '0;
      acc_ymin <= MIN_INIT;
      acc_ymax <= '0;
    end else if (acc_clr) begin
      acc_cnt  <= '0;
      acc_xmin <= MIN_INIT;
      acc_xmax <= '0;
      acc_ymin <= MIN_INIT;
      acc_ymax <= '0;
    end else if (acc_hit) begin
      if (acc_cnt != CNT_MAX) begin
        acc_cnt <= acc_cnt + 19'd1;
      end
      if (px_x < acc_xmin) acc_xmin <= px_x;
      if (px_x > acc_xmax) acc_xmax <= px_x;
      if (px_y < acc_ymin) acc_ymin <= px_y;
      if (px_y > acc_ymax) acc_ymax <= px_y;
    end
  end

  assign found_now = (acc_cnt >= MIN_HITS_C);

  // Published result and host handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      X_MIN    <= '0;
      X_MAX    <= '0;
      Y_MIN    <= '0;
      Y_MAX    <= '0;
      HIT_CNT  <= '0;
      FOUND    <= 1'b0;
      VALID    <= 1'b0;
      DROP_CNT <= '0;
    end else if (do_publish) begin
      HIT_CNT <= acc_cnt;
      FOUND   <= found_now;
      X_MIN   <= found_now ? acc_xmin : 10'd0;
      X_MAX   <= found_now ? acc_xmax : 10'd0;
      Y_MIN   <= found_now ? acc_ymin : 10'd0;
      Y_MAX   <= found_now ? acc_ymax : 10'd0;
      VALID   <= 1'b1;
      if (VALID && !ACK && (DROP_CNT != DROP_MAX)) begin
        DROP_CNT <= DROP_CNT + 8'd1;
      end
    end else if (VALID && ACK) begin
      VALID <= 1'b0;
    end
  end

endmodule
